rr_sel_mux: RTL and testbench
=============================

// Module: rr_sel_mux
// PURPOSE
// - N-channel, W-bit registered selector with valid/ready handshake on every input and on the output.
// - Successor to the plain combinational sel-case mux: the select is generated internally, not driven by a port.
// - Arbitration mode is fixed-priority or round-robin, chosen at run time.
// - Sits between several producers and one shared consumer, e.g. a bus or result port.
// PARAMETERS
// - N     4  number of input channels, N >= 2; need not be a power of 2
// - W     4  data width per channel
// - SELW  2  select width; must equal clog2(N) and is checked by an elaboration assertion
// PORTS
// - clk       in   1      single clock; all state updates on the rising edge
// - rst       in   1      synchronous, active-high reset
// - rr_en     in   1      1 = round-robin arbitration, 0 = fixed priority (lowest index wins)
// - in_valid  in   N      per-channel valid
// - in_data   in   N*W    channel i occupies bits [i*W +: W]
// - in_ready  out  N      per-channel ready; combinational, one-hot or zero
// - out_valid out  1      output beat held in the register
// - out_data  out  W      registered data of the granted channel
// - out_sel   out  SELW   index of the channel that supplied out_data
// - out_ready in   1      consumer accepts the beat when out_valid && out_ready
// BEHAVIOUR
// - Reset values: out_valid=0, out_data=0, out_sel=0, last_grant=N-1, so the first round-robin grant is channel 0.
// - Reset acts in any cycle and discards a held beat.
// - Capture condition: load = !out_valid || out_ready.
//   - The output register accepts a new beat only when load=1.
//   - Full throughput: one beat per cycle with out_ready held high.
// - Grant, computed only from valid channels and defined for every combination of in_valid:
//   - rr_en=0: lowest index i with in_valid[i]=1.
//   - rr_en=1: first valid index scanning last_grant+1, +2, ... modulo N; wraps from N-1 to 0.
// - in_ready[g] = load && any in_valid, where g is the grant. All other in_ready bits are 0.
//   - in_ready never depends on in_data.
// - Transfer from channel g happens when in_valid[g] && in_ready[g]. On that edge:
//   - out_data <= in_data[g]; out_sel <= g; out_valid <= 1; last_grant <= g.
// - Latency: a beat accepted at edge k is visible on out_* after edge k, for exactly one cycle if out_ready=1.
// - load=1 with no valid channel: out_valid <= 0. out_data and out_sel hold their last values.
// - Stall (out_valid && !out_ready):
//   - out_valid, out_data and out_sel hold; every in_ready bit is 0.
//   - last_grant is unchanged.
// - Simultaneous out_ready and a new input in one cycle: the old beat leaves and the new beat loads on the same edge, with no bubble.
// - last_grant updates in both modes.
//   - Toggling rr_en affects the next grant only; no beat is lost or duplicated.
// - out_sel never takes a value >= N.
// - No latches: every combinational signal has a defined value for every input, including values of the
//   select/grant encoding that cannot occur.
// STRUCTURE
// - Package rr_sel_pkg holds:
//   - arb_mode_t enum (ARB_FIXED, ARB_RR)
//   - clog2 helper function
//   - default N and W constants
// - Sub-module rr_pick (combinational):
//   - inputs: valid vector, last_grant, mode
//   - outputs: grant index and any_valid
//   - implemented with a rotate-then-priority-encode
// - The top level holds the output register, the last_grant register and the load/ready logic.
// TESTING
// - Reset: rst=1 for 2 cycles with in_valid=4'b1111 -> out_valid=0, in_ready=0, out_sel=0; after release the first grant is 0.
// - Fixed priority: rr_en=0, in_valid=4'b1010, data 3=4'hC, 1=4'h5, out_ready=1
//   -> out_sel=1, out_data=5 on every beat; channel 3 is starved.
// - Round robin: rr_en=1, in_valid=4'b1111, out_ready=1 -> out_sel sequence 0,1,2,3,0, one beat per cycle.
// - Non-power-of-2 wrap: N=3, rr_en=1, all valid -> out_sel sequence 0,1,2,0; sel value 3 never appears.
// - Backpressure: out_ready=0 for 3 cycles while holding beat 4'h7 from channel 2
//   -> out_data stays 7, in_ready=0, and after release the next grant is channel 3.
// - Mid-stream events:
//   - Toggle rr_en 1->0 with last_grant=0 and in_valid=4'b0011 -> next out_sel=0.
//   - Assert rst while out_valid=1 -> out_valid=0 on the next cycle.

Source files
------------

// File: rtl/rr_sel_pkg.sv
// Shared types and constants for the round-robin / fixed-priority selector.
package rr_sel_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

  localparam int DEFAULT_N = 4;
  localparam int DEFAULT_W = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_sel_mux_if.sv
// Producer-side and consumer-side handshake bundle for rr_sel_mux.
// A beat moves on a rising edge exactly when valid && ready; valid never waits on ready.
interface rr_sel_mux_if
  import rr_sel_pkg::*;
#(
  parameter int N    = DEFAULT_N,
  parameter int W    = DEFAULT_W,
  parameter int SELW = 2
);
  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_sel;
  logic            out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational grant picker: rotate the valid vector so the search starts
// after last_grant (or at 0 in fixed mode), then priority-encode the lowest bit.
module rr_pick
  import rr_sel_pkg::*;
#(
  parameter int N    = DEFAULT_N,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    valid,
  input  logic [SELW-1:0] last_grant,
  input  arb_mode_t       mode,
  output logic [SELW-1:0] grant,
  output logic            any_valid
);

  int             start;
  int             pos;
  int             idx;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  always_comb begin
    // An out-of-range last_grant falls back to starting at channel 0.
    start = 0;
    if (mode == ARB_RR && int'(last_grant) < N - 1) start = int'(last_grant) + 1;
    dbl = {valid, valid} >> start;
    rot = dbl[N-1:0];
    pos = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) pos = i;
    end
    idx = start + pos;
    if (idx >= N) idx = idx - N;
    grant     = SELW'(idx);
    any_valid = |valid;
  end

endmodule

// File: rtl/rr_sel_mux.sv
// N-channel registered selector: internal arbiter picks a producer, the
// output register holds one beat for the shared consumer.
module rr_sel_mux
  import rr_sel_pkg::*;
#(
  parameter int N    = DEFAULT_N,
  parameter int W    = DEFAULT_W,
  parameter int SELW = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rr_en,
  rr_sel_mux_if.slave  bus
);

  if (SELW != clog2(N)) begin : g_selw_check
    $error("rr_sel_mux: SELW must equal clog2(N)");
  end
  if (N < 2) begin : g_n_check
    $error("rr_sel_mux: N must be at least 2");
  end

  logic            out_valid_q;
  logic [W-1:0]    out_data_q;
  logic [SELW-1:0] out_sel_q;
  logic [SELW-1:0] last_grant;
  logic [SELW-1:0] grant;
  logic            any_valid;
  logic            load;
  arb_mode_t       mode;

  assign mode = rr_en ? ARB_RR : ARB_FIXED;

  rr_pick #(
    .N    (N),
    .SELW (SELW)
  ) u_pick (
    .valid      (bus.in_valid),
    .last_grant (last_grant),
    .mode       (mode),
    .grant      (grant),
    .any_valid  (any_valid)
  );

  // Register may take a beat when empty or when the held beat leaves this edge.
  assign load = !rst && (!out_valid_q || bus.out_ready);

  assign bus.in_ready  = (load && any_valid) ? (N'(1) << grant) : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      last_grant  <= SELW'(N - 1);
    end else if (load) begin
      if (any_valid) begin
        out_valid_q <= 1'b1;
        out_data_q  <= W'(bus.in_data >> (int'(grant) * W));
        out_sel_q   <= grant;
        last_grant  <= grant;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_sel_mux.sv
// Bench for rr_sel_mux: a 4-channel and a 3-channel instance share stimulus
// and are checked against an arithmetic reference model and a beat scoreboard.
module tb_rr_sel_mux;
  import rr_sel_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic rr_en;
  always #5 clk = ~clk;

  rr_sel_mux_if #(.N(4), .W(4), .SELW(2)) bus4 ();
  rr_sel_mux_if #(.N(3), .W(4), .SELW(2)) bus3 ();

  rr_sel_mux #(.N(4), .W(4), .SELW(2)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .rr_en (rr_en),
    .bus   (bus4.slave)
  );

  rr_sel_mux #(.N(3), .W(4), .SELW(2)) dut3 (
    .clk   (clk),
    .rst   (rst),
    .rr_en (rr_en),
    .bus   (bus3.slave)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // ---------------- reference model state ----------------
  logic       m_valid [2];
  logic [3:0] m_data  [2];
  int         m_sel   [2];
  int         m_last  [2];
  logic [5:0] exp_q4[$];
  logic [5:0] exp_q3[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Grant from the rules: fixed = lowest valid index; round robin = first valid
  // index after last grant, counting modulo n.
  function automatic int ref_grant(input int n, input int last, input logic [3:0] v, input logic rr);
    int g;
    int idx;
    g = -1;
    for (int k = 1; k <= n; k++) begin
      idx = rr ? (last + k) % n : k - 1;
      if (g < 0 && v[idx]) g = idx;
    end
    return g;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic rr, input logic [3:0] v,
                       input logic [15:0] d, input logic ordy);
    rst            = r;
    rr_en          = rr;
    bus4.in_valid  = v;
    bus4.in_data   = d;
    bus4.out_ready = ordy;
    bus3.in_valid  = v[2:0];
    bus3.in_data   = d[11:0];
    bus3.out_ready = ordy;
  endtask

  // One clock: check ready + departing beat before the edge, advance model, check register after.
  task automatic step();
    int         n;
    int         g;
    logic       ld;
    logic [3:0] exp_rdy;
    logic [5:0] beat;
    #1;
    for (int k = 0; k < 2; k++) begin
      n       = (k == 0) ? 4 : 3;
      ld      = !rst && (!m_valid[k] || bus4.out_ready);
      g       = ref_grant(n, m_last[k], bus4.in_valid, rr_en);
      exp_rdy = (ld && g >= 0) ? 4'(1 << g) : 4'b0000;
      if (k == 0) chk("in_ready4", 32'(bus4.in_ready), 32'(exp_rdy));
      else        chk("in_ready3", 32'(bus3.in_ready), 32'(exp_rdy[2:0]));
    end
    if (!rst && bus4.out_valid === 1'b1 && bus4.out_ready) begin
      chk("sb_nonempty4", 32'(exp_q4.size() > 0), 32'd1);
      if (exp_q4.size() > 0) begin
        beat = exp_q4.pop_front();
        chk("sb_beat4", 32'({bus4.out_sel, bus4.out_data}), 32'(beat));
      end
    end
    if (!rst && bus3.out_valid === 1'b1 && bus3.out_ready) begin
      chk("sb_nonempty3", 32'(exp_q3.size() > 0), 32'd1);
      if (exp_q3.size() > 0) begin
        beat = exp_q3.pop_front();
        chk("sb_beat3", 32'({bus3.out_sel, bus3.out_data}), 32'(beat));
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? 4 : 3;
      if (rst) begin
        m_valid[k] = 1'b0;
        m_data[k]  = 4'h0;
        m_sel[k]   = 0;
        m_last[k]  = n - 1;
        if (k == 0) exp_q4.delete(); else exp_q3.delete();
      end else if (!m_valid[k] || bus4.out_ready) begin
        g = ref_grant(n, m_last[k], bus4.in_valid, rr_en);
        if (g >= 0) begin
          m_valid[k] = 1'b1;
          m_data[k]  = bus4.in_data[g*4 +: 4];
          m_sel[k]   = g;
          m_last[k]  = g;
          if (k == 0) exp_q4.push_back({2'(g), m_data[k]});
          else        exp_q3.push_back({2'(g), m_data[k]});
        end else begin
          m_valid[k] = 1'b0;
        end
      end
    end
    @(negedge clk);
    chk("out_valid4", 32'(bus4.out_valid), 32'(m_valid[0]));
    chk("out_data4",  32'(bus4.out_data),  32'(m_data[0]));
    chk("out_sel4",   32'(bus4.out_sel),   32'(m_sel[0]));
    chk("out_valid3", 32'(bus3.out_valid), 32'(m_valid[1]));
    chk("out_data3",  32'(bus3.out_data),  32'(m_data[1]));
    chk("out_sel3",   32'(bus3.out_sel),   32'(m_sel[1]));
    chk("sel_range3", 32'(bus3.out_sel < 2'd3), 32'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    // Reset with every channel requesting.
    drive(1'b1, 1'b1, 4'b1111, 16'hDCBA, 1'b1);
    step();
    step();
    chk("rst_valid4", 32'(bus4.out_valid), 32'd0);
    chk("rst_sel4",   32'(bus4.out_sel),   32'd0);

    // Round robin straight after reset: 0,1,2,3,0 and 0,1,2,0,1.
    drive(1'b0, 1'b1, 4'b1111, 16'hDCBA, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_seq4",  32'(bus4.out_sel),  32'(i % 4));
      chk("rr_data4", 32'(bus4.out_data), 32'(4'hA + 4'(i % 4)));
      chk("rr_seq3",  32'(bus3.out_sel),  32'(i % 3));
    end

    // Fixed priority: channel 1 wins every beat, channel 3 starves.
    drive(1'b0, 1'b0, 4'b1010, 16'hC050, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fix_sel4",   32'(bus4.out_sel),   32'd1);
      chk("fix_data4",  32'(bus4.out_data),  32'h5);
      chk("fix_valid4", 32'(bus4.out_valid), 32'd1);
    end

    // Backpressure while holding 7 from channel 2.
    drive(1'b0, 1'b1, 4'b0100, 16'h0700, 1'b1);
    step();
    chk("bp_load_data4", 32'(bus4.out_data), 32'h7);
    drive(1'b0, 1'b1, 4'b1111, 16'h4321, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_data4", 32'(bus4.out_data), 32'h7);
      chk("bp_hold_sel4",  32'(bus4.out_sel),  32'd2);
      chk("bp_ready4",     32'(bus4.in_ready), 32'd0);
    end
    drive(1'b0, 1'b1, 4'b1111, 16'h4321, 1'b1);
    step();
    chk("bp_next_sel4",  32'(bus4.out_sel),  32'd3);
    chk("bp_next_data4", 32'(bus4.out_data), 32'h4);
    chk("bp_next_sel3",  32'(bus3.out_sel),  32'd0);

    // Mode toggle 1->0 with last grant 0: fixed picks channel 0, not 1.
    drive(1'b0, 1'b1, 4'b0001, 16'h000E, 1'b1);
    step();
    drive(1'b0, 1'b0, 4'b0011, 16'h0021, 1'b1);
    step();
    chk("toggle_sel4",  32'(bus4.out_sel),  32'd0);
    chk("toggle_data4", 32'(bus4.out_data), 32'h1);

    // Random traffic, occasional reset.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 4'($urandom),
            16'($urandom), ($urandom_range(0, 3) != 0));
      step();
    end

    // Reset while a beat is held.
    drive(1'b0, 1'b1, 4'b1111, 16'h9876, 1'b0);
    step();
    chk("pre_rst_valid4", 32'(bus4.out_valid), 32'd1);
    drive(1'b1, 1'b1, 4'b1111, 16'h9876, 1'b0);
    step();
    chk("mid_rst_valid4", 32'(bus4.out_valid), 32'd0);
    chk("mid_rst_valid3", 32'(bus3.out_valid), 32'd0);
    drive(1'b0, 1'b1, 4'b0000, 16'h0000, 1'b1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
